// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_pkg : shared widths and state encoding for the SPI-master I/O block |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package io_pkg;

  localparam int c_DATA_WIDTH = 8;
  localparam int c_ADDR_WIDTH = 4;
  localparam int c_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } io_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shifter : half-period divider, bit counter and TX/RX shift regs    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_shifter
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int CLK_DIV    = c_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_byte,
  input  logic                  i_run,
  input  logic                  i_sample,
  input  logic                  i_shift,
  input  logic                  i_miso,
  output logic                  o_div_done,
  output logic                  o_last_bit,
  output logic                  o_mosi_bit,
  output logic [DATA_WIDTH-1:0] o_rx_byte
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BIT_W = $clog2(DATA_WIDTH);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

  logic [c_DIV_W-1:0]    r_div_cnt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic [DATA_WIDTH-1:0] r_rx_sr;

  assign o_div_done = (r_div_cnt == c_DIV_LAST);
  assign o_last_bit = (r_bit_cnt == c_BIT_LAST);
  assign o_mosi_bit = r_tx_sr[DATA_WIDTH-1];
  assign o_rx_byte  = r_rx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
    end else begin
      // Divider restarts at every phase boundary so each half-period is exact
      if (!i_run || o_div_done) r_div_cnt <= '0;
      else                      r_div_cnt <= r_div_cnt + 1'b1;

      // A byte load wins over the shift on the last falling edge of a byte
      if (i_load) begin
        r_tx_sr   <= i_load_byte;
        r_bit_cnt <= '0;
      end else if (i_shift) begin
        r_tx_sr   <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (i_sample) r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], i_miso};
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_module.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_module : SPI master with TX/RX byte buffers and CS-framed bursts    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module io_module
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int CLK_DIV    = c_CLK_DIV
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  send,
  output logic                  io_complete,
  input  logic [ADDR_WIDTH-1:0] tx_addr,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  input  logic                  tx_wr,
  input  logic [ADDR_WIDTH-1:0] rx_addr,
  output logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  rx_rd,
  output logic                  spiClk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam int c_CNT_W = ADDR_WIDTH + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_DEPTH);

  logic [DATA_WIDTH-1:0] r_tx_buf [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_buf [c_DEPTH];

  io_state_t             r_state, w_next_state;
  logic                  r_send_q, r_send_prev;
  logic [c_CNT_W-1:0]    r_tx_count, r_byte_idx, w_next_idx;
  logic                  r_io_complete;
  logic [DATA_WIDTH-1:0] r_rx_byte;

  logic                  w_start, w_active, w_run, w_more;
  logic                  w_bit_end, w_byte_end, w_load, w_tx_we;
  logic [ADDR_WIDTH-1:0] w_load_idx;
  logic [DATA_WIDTH-1:0] w_load_byte;
  logic                  w_div_done, w_last_bit, w_mosi_bit;
  logic [DATA_WIDTH-1:0] w_rx_shift;

  assign w_start    = (r_state == ST_IDLE) && r_send_prev && !r_send_q;
  assign w_next_idx = r_byte_idx + 1'b1;
  assign w_more     = (w_next_idx < r_tx_count);
  assign w_bit_end  = (r_state == ST_HIGH) && w_div_done;
  assign w_byte_end = w_bit_end && w_last_bit;
  assign w_load     = (w_start && (r_tx_count != '0)) || (w_byte_end && w_more);
  assign w_load_idx = w_start ? '0 : w_next_idx[ADDR_WIDTH-1:0];
  assign w_load_byte = r_tx_buf[w_load_idx];
  // A write coinciding with the start edge would change N mid-burst
  assign w_tx_we    = (r_state == ST_IDLE) && !tx_wr && !w_start;

  assign w_run    = (r_state == ST_LOW) || (r_state == ST_HIGH);
  assign w_active = w_run || (r_state == ST_LOAD);

  assign cs          = !w_active;
  assign spiClk      = (r_state == ST_HIGH);
  assign mosi        = w_active && w_mosi_bit;
  assign io_complete = r_io_complete;
  assign rx_byte     = r_rx_byte;

  spi_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_shifter (
    .clk         (sysClk),
    .rst         (reset),
    .i_load      (w_load),
    .i_load_byte (w_load_byte),
    .i_run       (w_run),
    .i_sample    ((r_state == ST_LOW) && w_div_done),
    .i_shift     (w_bit_end && !w_last_bit),
    .i_miso      (miso),
    .o_div_done  (w_div_done),
    .o_last_bit  (w_last_bit),
    .o_mosi_bit  (w_mosi_bit),
    .o_rx_byte   (w_rx_shift)
  );

  always_ff @(posedge sysClk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next_state = (r_tx_count == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: w_next_state = ST_LOW;
      ST_LOW:  if (w_div_done) w_next_state = ST_HIGH;
      ST_HIGH: if (w_bit_end) w_next_state = (w_last_bit && !w_more) ? ST_DONE : ST_LOW;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      r_send_q      <= 1'b1;
      r_send_prev   <= 1'b1;
      r_tx_count    <= '0;
      r_byte_idx    <= '0;
      r_io_complete <= 1'b0;
      r_rx_byte     <= '0;
    end else begin
      r_send_q    <= send;
      r_send_prev <= r_send_q;

      if (w_next_state == ST_DONE) r_io_complete <= 1'b1;
      else if (w_start)            r_io_complete <= 1'b0;

      if (w_start)                    r_byte_idx <= '0;
      else if (w_byte_end && w_more)  r_byte_idx <= w_next_idx;

      if (r_state == ST_DONE)                        r_tx_count <= '0;
      else if (w_tx_we && (r_tx_count != c_CNT_MAX)) r_tx_count <= r_tx_count + 1'b1;

      if (!rx_rd) r_rx_byte <= r_rx_buf[rx_addr];
    end
  end

  // Buffer contents survive reset; an aborted byte is never stored
  always_ff @(posedge sysClk) begin
    if (!reset) begin
      if (w_tx_we)    r_tx_buf[tx_addr] <= tx_byte;
      if (w_byte_end) r_rx_buf[r_byte_idx[ADDR_WIDTH-1:0]] <= w_rx_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_module.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_io_module : randomized self-checking bench with echo SPI slave      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_io_module;
  import io_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;

  logic       sysClk = 1'b0;
  logic       reset  = 1'b1;
  logic       send   = 1'b1;
  logic       tx_wr  = 1'b1;
  logic       rx_rd  = 1'b1;
  logic       miso   = 1'b0;
  logic [3:0] tx_addr = '0;
  logic [3:0] rx_addr = '0;
  logic [7:0] tx_byte = '0;
  logic       io_complete, spiClk, mosi, cs;
  logic [7:0] rx_byte;

  io_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLK_DIV(CLK_DIV)) dut (
    .sysClk(sysClk), .reset(reset), .send(send), .io_complete(io_complete),
    .tx_addr(tx_addr), .tx_byte(tx_byte), .tx_wr(tx_wr),
    .rx_addr(rx_addr), .rx_byte(rx_byte), .rx_rd(rx_rd),
    .spiClk(spiClk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  always #5 sysClk = ~sysClk;

  // Echo slave: samples mosi on rise, shifts and presents its MSB after fall
  logic [7:0] slv_sr   = '0;
  logic       slv_prev = 1'b0;
  logic       slv_bit  = 1'b0;
  always @(posedge sysClk) begin
    slv_prev <= spiClk;
    if (cs) begin
      slv_sr <= '0;
      miso   <= 1'b0;
    end else if (spiClk && !slv_prev) begin
      slv_bit <= mosi;
    end else if (!spiClk && slv_prev) begin
      slv_sr <= {slv_sr[6:0], slv_bit};
      miso   <= slv_sr[6];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_tx [DEPTH];
  logic [7:0] m_rx [DEPTH];
  int m_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic write_tx(input int a, input logic [7:0] b);
    tx_addr = 4'(a);
    tx_byte = b;
    tx_wr   = 1'b0;
    tick();
    tx_wr   = 1'b1;
    m_tx[a] = b;
    if (m_count < DEPTH) m_count++;
  endtask

  task automatic read_rx(input int a);
    rx_addr = 4'(a);
    rx_rd   = 1'b0;
    tick();
    rx_rd   = 1'b1;
    chk($sformatf("rx%0d", a), 32'(rx_byte), 32'(m_rx[a]));
  endtask

  // Runs one burst of the model's current length; abort_at>0 resets after that many rises
  task automatic run_burst(input int abort_at, input bit glitch);
    int n, c, cs_fall_cyc, cs_rise_cyc, cs_falls, cs_low, rises;
    int first_rise, last_rise, bad_int, mosi_bad, done_cyc;
    logic p_cs, p_sck, p_mosi, p_io;
    logic [7:0] got_b;
    logic bits[$];
    n = m_count;
    send = 1'b1;
    tick();
    tick();
    send = 1'b0;
    c = -1; cs_fall_cyc = -1; cs_rise_cyc = -2; cs_falls = 0; cs_low = 0; rises = 0;
    first_rise = -1; last_rise = 0; bad_int = 0; mosi_bad = 0; done_cyc = -1;
    p_cs = cs; p_sck = spiClk; p_mosi = mosi; p_io = io_complete;
    for (int k = 0; k < 4000 && done_cyc < 0; k++) begin
      tick();
      c++;
      if (!cs && p_cs) begin
        cs_falls++;
        if (cs_fall_cyc < 0) cs_fall_cyc = c;
      end
      if (cs && !p_cs) cs_rise_cyc = c;
      if (!cs) cs_low++;
      if (spiClk && !p_sck) begin
        rises++;
        bits.push_back(mosi);
        if (first_rise < 0) first_rise = c;
        else if (c - last_rise != 2 * CLK_DIV) bad_int++;
        last_rise = c;
      end
      if ((mosi !== p_mosi) && !(p_sck && !spiClk) && (cs === p_cs)) mosi_bad++;
      if (io_complete && !p_io) done_cyc = c;
      p_cs = cs; p_sck = spiClk; p_mosi = mosi; p_io = io_complete;
      if (glitch && !cs) begin
        tx_wr   = ($urandom_range(0, 1) == 0);
        tx_addr = 4'($urandom_range(0, n - 2));
        tx_byte = 8'($urandom);
      end else begin
        tx_wr = 1'b1;
      end
      if (abort_at > 0 && rises == abort_at) begin
        tx_wr = 1'b1;
        reset = 1'b1;
        send  = 1'b1;
        tick();
        chk("abort_cs", 32'(cs), 32'(1));
        chk("abort_sck", 32'(spiClk), 32'(0));
        chk("abort_mosi", 32'(mosi), 32'(0));
        reset = 1'b0;
        m_count = 0;
        m_rx[0] = 8'h00;
        return;
      end
    end
    tx_wr = 1'b1;
    chk("burst_timeout", 32'(done_cyc >= 0), 32'(1));
    chk("cs_fall_cyc", cs_fall_cyc, 1);
    chk("cs_falls", cs_falls, 1);
    chk("first_rise", first_rise, 2 + CLK_DIV);
    chk("rises", rises, 8 * n);
    // one LOAD cycle precedes the 8*N back-to-back bit periods
    chk("cs_low", cs_low, 16 * n * CLK_DIV + 1);
    chk("bit_period", bad_int, 0);
    chk("mosi_edges", mosi_bad, 0);
    chk("done_with_cs", done_cyc, cs_rise_cyc);
    chk("idle_lines", 32'({spiClk, mosi}), 32'(0));
    for (int b = 0; b < n; b++) begin
      got_b = '0;
      for (int i = 0; i < 8; i++)
        if (8 * b + i < bits.size()) got_b = {got_b[6:0], bits[8 * b + i]};
      chk($sformatf("mosi_byte%0d", b), 32'(got_b), 32'(m_tx[b]));
    end
    for (int k = n - 1; k >= 0; k--) m_rx[k] = (k == 0) ? 8'h00 : m_tx[k - 1];
    m_count = 0;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_cs", 32'(cs), 32'(1));
    chk("rst_sck", 32'(spiClk), 32'(0));
    chk("rst_complete", 32'(io_complete), 32'(0));
    chk("rst_rx_byte", 32'(rx_byte), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(0));
    reset = 1'b0;
    tick();

    write_tx(0, 8'hA1);
    write_tx(1, 8'h2A);
    write_tx(2, 8'h32);
    run_burst(0, 1'b0);
    read_rx(0);
    read_rx(1);
    read_rx(2);
    rx_addr = 4'd0;
    tick();
    chk("rx_hold", 32'(rx_byte), 32'(m_rx[2]));

    cnt = 0;
    repeat (40) begin
      tick();
      if (!cs) cnt++;
    end
    chk("no_retrigger", cnt, 0);
    chk("complete_held", 32'(io_complete), 32'(1));
    send = 1'b1;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    send = 1'b0;
    tick();
    chk("empty_T", 32'(io_complete), 32'(0));
    tick();
    chk("empty_T1", 32'(io_complete), 32'(1));
    cnt = 0;
    repeat (10) begin
      tick();
      if (!cs) cnt++;
    end
    chk("empty_no_cs", cnt, 0);
    send = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) write_tx(i, 8'($urandom));
    run_burst(11, 1'b0);
    read_rx(1);
    read_rx(0);
    write_tx(0, 8'h5A);
    run_burst(0, 1'b0);
    send = 1'b1;
    read_rx(0);

    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) write_tx(i, 8'($urandom));
    run_burst(0, 1'b1);
    send = 1'b1;
    for (int i = 0; i < n; i++) write_tx(n - 1, m_tx[n - 1]);
    run_burst(0, 1'b0);
    send = 1'b1;
    for (int k = 0; k < n; k++) read_rx(k);

    for (int i = 0; i < 18; i++) write_tx(i % DEPTH, 8'($urandom));
    chk("saturated_count", m_count, DEPTH);
    run_burst(0, 1'b0);
    send = 1'b1;
    for (int k = 0; k < DEPTH; k++) read_rx(k);

    repeat (3) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) write_tx($urandom_range(0, DEPTH - 1), 8'($urandom));
      run_burst(0, 1'b0);
      send = 1'b1;
      for (int k = 0; k < 4; k++) read_rx($urandom_range(0, DEPTH - 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
